// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths, channel-index width helper and phase/tune types.
package dds_pkg;
   localparam int DEF_CHANNELS   = 4;
   localparam int DEF_ACC_WIDTH  = 23;
   localparam int DEF_OUT_WIDTH  = 14;
   localparam int DEF_TUNE_WIDTH = 16;

   typedef logic [DEF_ACC_WIDTH-1:0]  phase_t;
   typedef logic [DEF_TUNE_WIDTH-1:0] tune_t;

   // A single voice still needs a one-bit channel tag.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/phase_slot_adder.sv
// Shared accumulate stage: phase + zero-extended tuning word with carry-out;
// a hard-sync on the serviced voice forces a zero result and no wrap.
module phase_slot_adder
   import dds_pkg::*;
#(
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int TUNE_WIDTH = DEF_TUNE_WIDTH
) (
   input  logic [ACC_WIDTH-1:0]  i_phase,
   input  logic [TUNE_WIDTH-1:0] i_tune,
   input  logic                  i_sync,
   output logic [ACC_WIDTH-1:0]  o_sum,
   output logic                  o_carry
);
   logic [ACC_WIDTH:0] w_full;

   assign w_full = {1'b0, i_phase} + (ACC_WIDTH+1)'(i_tune);

   always_comb begin
      o_sum   = w_full[ACC_WIDTH-1:0];
      o_carry = w_full[ACC_WIDTH];
      if (i_sync) begin
         o_sum   = '0;
         o_carry = 1'b0;
      end
   end
endmodule

// File: rtl/multi_phase_accumulator.sv
// Round-robin multi-voice DDS phase accumulator sharing one adder across CHANNELS voices.
// Define PHASE_OFFSET_EN to add wr_sel and a per-voice output phase offset.
module multi_phase_accumulator
   import dds_pkg::*;
#(
   parameter int  CHANNELS   = DEF_CHANNELS,
   parameter int  ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int  OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int  TUNE_WIDTH = DEF_TUNE_WIDTH,
   localparam int CH_W       = ch_w(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  wr_en,
   input  logic [CH_W-1:0]       wr_ch,
   input  logic [TUNE_WIDTH-1:0] wr_tune,
`ifdef PHASE_OFFSET_EN
   input  logic                  wr_sel,
`endif
   input  logic                  sync,
   input  logic [CH_W-1:0]       sync_ch,
   output logic                  phase_valid,
   output logic [CH_W-1:0]       phase_ch,
   output logic [OUT_WIDTH-1:0]  phase_out,
   output logic                  phase_wrap
);
   logic [CH_W-1:0]       r_ch_idx;
   logic [ACC_WIDTH-1:0]  r_phase [CHANNELS];
   logic [TUNE_WIDTH-1:0] r_tune  [CHANNELS];

   logic                  r_valid;
   logic [CH_W-1:0]       r_ch;
   logic [OUT_WIDTH-1:0]  r_phase_out;
   logic                  r_wrap;

   logic                  w_sync_hit;
   logic                  w_tune_we;
   logic [ACC_WIDTH-1:0]  w_sum;
   logic                  w_carry;
   logic [OUT_WIDTH-1:0]  w_phase_trunc;
   logic [OUT_WIDTH-1:0]  w_phase_next;

   assign w_sync_hit = sync && (sync_ch == r_ch_idx);

   phase_slot_adder #(
      .ACC_WIDTH  (ACC_WIDTH),
      .TUNE_WIDTH (TUNE_WIDTH)
   ) u_adder (
      .i_phase (r_phase[r_ch_idx]),
      .i_tune  (r_tune[r_ch_idx]),
      .i_sync  (w_sync_hit),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_phase_trunc = w_sum[ACC_WIDTH-1 -: OUT_WIDTH];

`ifdef PHASE_OFFSET_EN
   logic [OUT_WIDTH-1:0] r_off [CHANNELS];
   logic [OUT_WIDTH-1:0] w_off_wdata;

   // Offset writes take the low bits of the tuning-word bus, zero-extended if narrower.
   assign w_off_wdata  = OUT_WIDTH'(wr_tune);
   assign w_tune_we    = wr_en && !wr_sel;
   assign w_phase_next = w_phase_trunc + r_off[r_ch_idx];

   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            r_off[i] <= '0;
         end else if (wr_en && wr_sel && (wr_ch == CH_W'(i))) begin
            r_off[i] <= w_off_wdata;
         end
      end
   end
`else
   assign w_tune_we    = wr_en;
   assign w_phase_next = w_phase_trunc;
`endif

   // Sync clears a voice regardless of ce; tune writes land after the old word was used.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            r_phase[i] <= '0;
            r_tune[i]  <= '0;
         end else begin
            if (sync && (sync_ch == CH_W'(i))) begin
               r_phase[i] <= '0;
            end else if (ce && (r_ch_idx == CH_W'(i))) begin
               r_phase[i] <= w_sum;
            end
            if (w_tune_we && (wr_ch == CH_W'(i))) begin
               r_tune[i] <= wr_tune;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch_idx    <= '0;
         r_valid     <= 1'b0;
         r_ch        <= '0;
         r_phase_out <= '0;
         r_wrap      <= 1'b0;
      end else begin
         r_valid <= ce;
         if (ce) begin
            r_ch_idx    <= (r_ch_idx == CH_W'(CHANNELS - 1)) ? '0 : r_ch_idx + 1'b1;
            r_ch        <= r_ch_idx;
            r_phase_out <= w_phase_next;
            r_wrap      <= w_carry;
         end
      end
   end

   assign phase_valid = r_valid;
   assign phase_ch    = r_ch;
   assign phase_out   = r_phase_out;
   assign phase_wrap  = r_wrap;
endmodule

// File: tb/tb_multi_phase_accumulator.sv
// Self-checking bench for multi_phase_accumulator: directed cases with literal expectations,
// then randomized traffic compared cycle by cycle against an arithmetic voice model.
`timescale 1ns/1ps
module tb_multi_phase_accumulator;
   localparam int NCH  = 4;
   localparam int ACCW = 23;
   localparam int OUTW = 14;
   localparam int MOD  = 1 << ACCW;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_tune;
   logic        sync;
   logic [1:0]  sync_ch;
   logic        phase_valid;
   logic [1:0]  phase_ch;
   logic [13:0] phase_out;
   logic        phase_wrap;

   int checks;
   int failures;

   int unsigned m_phase [NCH];
   int unsigned m_tune  [NCH];
   int          m_idx;
   int          exp_valid;
   int          exp_ch;
   int          exp_out;
   int          exp_wrap;

   multi_phase_accumulator dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_tune     (wr_tune),
`ifdef PHASE_OFFSET_EN
      .wr_sel      (1'b0),
`endif
      .sync        (sync),
      .sync_ch     (sync_ch),
      .phase_valid (phase_valid),
      .phase_ch    (phase_ch),
      .phase_out   (phase_out),
      .phase_wrap  (phase_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Voice model: each visit adds the voice's tuning word modulo 2^ACCW.
   task automatic model_update();
      int unsigned sum;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_phase[i] = 0;
            m_tune[i]  = 0;
         end
         m_idx = 0; exp_valid = 0; exp_ch = 0; exp_out = 0; exp_wrap = 0;
         return;
      end
      exp_valid = ce;
      if (ce) begin
         sum = m_phase[m_idx] + m_tune[m_idx];
         if (sync && int'(sync_ch) == m_idx) begin
            m_phase[m_idx] = 0;
            exp_wrap = 0;
         end else begin
            m_phase[m_idx] = sum % MOD;
            exp_wrap = (sum >= MOD) ? 1 : 0;
         end
         exp_ch  = m_idx;
         exp_out = int'(m_phase[m_idx] / (1 << (ACCW - OUTW)));
         m_idx   = (m_idx + 1) % NCH;
      end
      if (sync) m_phase[sync_ch] = 0;
      if (wr_en) m_tune[wr_ch] = wr_tune;
   endtask

   task automatic compare_outputs();
      check("valid", phase_valid, exp_valid);
      if (exp_valid != 0) begin
         check("ch", phase_ch, exp_ch);
         check("out", phase_out, exp_out);
         check("wrap", phase_wrap, exp_wrap);
      end
      $display("beat rst=%0b ce=%0b valid=%0b ch=%0d out=0x%0h wrap=%0b", rst, ce, phase_valid,
               phase_ch, phase_out, phase_wrap);
   endtask

   task automatic step(input logic c, input logic we, input int wch, input int wt,
                       input logic s, input int sch);
      ce = c; wr_en = we; wr_ch = wch[1:0]; wr_tune = wt[15:0]; sync = s; sync_ch = sch[1:0];
      model_update();
      @(posedge clk);
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 1'b0, 0, 0, 1'b0, 0);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; ce = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_tune = '0; sync = 1'b0; sync_ch = '0;
      @(negedge clk);

      // Reset state, then zero tuning words: channel tag rotates, phase stays 0.
      do_reset();
      check("rst_valid", phase_valid, 0);
      check("rst_ch", phase_ch, 0);
      check("rst_out", phase_out, 0);
      check("rst_wrap", phase_wrap, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 0, 0, 1'b0, 0);
         check("rot_ch", phase_ch, i % 4);
         check("rot_out", phase_out, 0);
      end

      // tune[2]=0x8000: output top bits advance 0x40 per visit.
      do_reset();
      step(1'b0, 1'b1, 2, 'h8000, 1'b0, 0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 0, 0, 1'b0, 0);
         if (i % 4 == 2) check("step2_out", phase_out, ((i / 4) + 1) * 'h40);
      end

      // tune[0]=0xFFFF: visit 128 is just below 2^23, visit 129 wraps.
      do_reset();
      step(1'b0, 1'b1, 0, 'hFFFF, 1'b0, 0);
      for (int i = 0; i < 129 * 4; i++) begin
         step(1'b1, 1'b0, 0, 0, 1'b0, 0);
         if (i == 127 * 4) begin
            check("v128_wrap", phase_wrap, 0);
            check("v128_out", phase_out, 'h3FFF);
         end
         if (i == 128 * 4) begin
            check("v129_wrap", phase_wrap, 1);
            check("v129_out", phase_out, 'h7F);
         end
      end

      // Tune write during that voice's own accumulate uses the old word.
      do_reset();
      step(1'b0, 1'b1, 1, 'h1000, 1'b0, 0);
      step(1'b1, 1'b0, 0, 0, 1'b0, 0);
      step(1'b1, 1'b1, 1, 'h4000, 1'b0, 0);
      check("wr_old_out", phase_out, 'h8);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0);
      check("wr_new_ch", phase_ch, 1);
      check("wr_new_out", phase_out, 'h28);

      // Hard sync on channel 3 during its accumulate, then with ce=0.
      do_reset();
      step(1'b0, 1'b1, 3, 'h2000, 1'b0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0);
      step(1'b1, 1'b0, 0, 0, 1'b1, 3);
      check("sync_ch", phase_ch, 3);
      check("sync_out", phase_out, 0);
      check("sync_wrap", phase_wrap, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0);
      check("after_sync_out", phase_out, 'h10);
      step(1'b0, 1'b0, 0, 0, 1'b1, 3);
      check("sync_ce0_valid", phase_valid, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0);
      check("after_sync2_out", phase_out, 'h10);

      // Randomized traffic against the model, including occasional mid-rotation reset.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 'hFFFF)), $urandom_range(0, 19) == 0,
              int'($urandom_range(0, 3)));
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multi_phase_accumulator.md
# multi_phase_accumulator

Time-multiplexed, multi-channel phase accumulator for the DDS synthesizer; next generation of the single-channel accumulator. One shared adder serves CHANNELS independent voices in round-robin order. Each voice has its own tuning word and hard-sync control, and reports wrap-around. Outputs feed the shared phase-to-amplitude lookup with a channel tag.

## Interface
- CHANNELS, 4: number of voices, ≥1
- ACC_WIDTH, 23: accumulator width n
- OUT_WIDTH, 14: truncated phase width m, ≤ ACC_WIDTH
- TUNE_WIDTH, 16: tuning word width, ≤ ACC_WIDTH
- CH_W (localparam): max($clog2(CHANNELS),1)

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ce  in  1  step enable; one channel is serviced per ce cycle
- wr_en  in  1  tuning-word write strobe
- wr_ch  in  CH_W  channel written
- wr_tune  in  TUNE_WIDTH  new tuning word
- sync  in  1  hard-sync strobe
- sync_ch  in  CH_W  channel to hard-sync
- phase_valid  out  1  output beat valid
- phase_ch  out  CH_W  channel of current beat
- phase_out  out  OUT_WIDTH  phase[ACC_WIDTH-1 -: OUT_WIDTH] of that channel
- phase_wrap  out  1  accumulator carry-out on this update

## Operation
- State: phase[CHANNELS] (ACC_WIDTH), tune[CHANNELS] (TUNE_WIDTH), slot counter ch_idx.
- Cycle with ce=1, ch_idx=k: phase[k] <= phase[k] + zero-extended tune[k], mod 2^ACC_WIDTH; carry-out captured as wrap; ch_idx advances k→k+1, CHANNELS-1→0.
- ce=0: no phase or ch_idx change; phase_valid=0 next cycle.
- Write: wr_en stores wr_tune into tune[wr_ch] at the clock edge. Same-cycle accumulate of that channel uses the OLD tune. wr_ch ≥ CHANNELS is ignored.
- Sync: sync clears phase[sync_ch] to 0 at the clock edge and overrides a same-cycle accumulate of that channel. That beat reports phase_out=0, wrap=0. sync_ch ≥ CHANNELS is ignored. Sync works with ce=0.
- Simultaneous wr_en and sync on the same channel: both take effect.
- CHANNELS=1: ch_idx stays 0; behaviour equals a single accumulator.

## Timing
- Latency 1: the beat for the ce cycle at edge t appears registered after edge t: phase_valid=1, phase_ch=k, phase_out = new phase[k] top bits, phase_wrap = carry.
- Throughput: one channel per ce cycle; each voice updates every CHANNELS ce cycles.
- Reset: all phase=0, all tune=0, ch_idx=0, phase_valid=0, phase_ch=0, phase_out=0, phase_wrap=0. rst dominates ce, wr_en and sync. Reset mid-rotation restarts at channel 0.

## Configuration
- PHASE_OFFSET_EN defined: adds input wr_sel (1 bit) and per-channel off[CHANNELS] (OUT_WIDTH, reset 0).
  - wr_en with wr_sel=1 writes wr_tune[OUT_WIDTH-1:0] (zero-extended if narrower) to off[wr_ch].
  - phase_out = truncated phase + off[k] mod 2^OUT_WIDTH, still latency 1.
  - phase_wrap is unaffected by the offset.
- Not defined: no wr_sel port, no offset storage; writes always target tune.

## Structure
- Shared package dds_pkg: default widths, CH_W computation function, phase/tune typedefs.
- Sub-module phase_slot_adder: combinational add with carry-out and sync override. Top holds storage, slot counter and output registers.

## Test plan
- Reset, CHANNELS=4, tune all 0, ce=1 -> phase_ch cycles 0,1,2,3,0; phase_out=0; wrap=0.
- tune[2]=0x8000, ACC_WIDTH=23 -> channel 2 phase steps 0x8000 per visit; phase_out increments by 0x40 per visit.
- tune[0]=0xFFFF, 128 visits -> wrap=1 exactly on the visit whose sum crosses 2^23; phase_out wraps to a small value.
- Write tune[1] during channel 1's accumulate cycle -> that beat uses the old word; the next visit uses the new one.
- sync on channel 3 during its accumulate, and with ce=0 -> beat shows 0, wrap 0; subsequent visits restart from tune[3].
- PHASE_OFFSET_EN, off[0]=0x2000, phase top bits 0x3000 -> phase_out=0x1000 (mod 2^14).
